// File: rtl/ip_yuv444to422.sv
// ip_yuv444to422: YCbCr 4:4:4 to line-synchronous 4:2:2 converter.
// One chroma sample per pixel slot: even slots carry the first chroma, odd slots the second
// chroma of the preceding even pixel. Every output trails its input pixel by 2 clk.
// Build option: define YUV422_FILT_EN for the [1 2 1]/4 horizontal chroma filter
// (co-sited on even pixels); left undefined, chroma is plainly decimated.
module ip_yuv444to422 #(
  parameter int unsigned DAT_SZ = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_href,
  input  logic              i_hstr,
  input  logic              i_hend,
  input  logic [DAT_SZ-1:0] i_data_y,
  input  logic [DAT_SZ-1:0] i_data_cb,
  input  logic [DAT_SZ-1:0] i_data_cr,
  input  logic              i_c_swap,
  output logic              o_href,
  output logic              o_hstr,
  output logic              o_hend,
  output logic              o_c_sel,
  output logic [DAT_SZ-1:0] o_data_y,
  output logic [DAT_SZ-1:0] o_data_c
);

  // Idle: stage 1 empty. Active: stage 1 holds a pixel whose successor is still unknown.
  // Flush: stage 1 holds the pixel marked by i_hend.
  typedef enum logic [1:0] {StIdle, StActive, StFlush} state_e;

  state_e state_q, state_d;

  // Stage 1: the pixel currently being filtered
  logic [DAT_SZ-1:0] s1_y_q, s1_y_d, s1_cb_q, s1_cb_d, s1_cr_q, s1_cr_d;
  logic              s1_par_q, s1_par_d, s1_hstr_q, s1_hstr_d, s1_swap_q, s1_swap_d;

  // Second-chroma result of the even pixel, replayed in the following odd slot
  logic [DAT_SZ-1:0] hold_q, hold_d;

  // Output registers
  logic              href_q, href_d, hstr_q, hstr_d, hend_q, hend_d, sel_q, sel_d;
  logic [DAT_SZ-1:0] y_q, y_d, c_q, c_d;

  logic              s1_vld, cont, take, last;
  logic [DAT_SZ-1:0] f_cb, f_cr, first_f, second_f;

`ifdef YUV422_FILT_EN
  localparam logic [DAT_SZ+1:0] Rnd = (DAT_SZ+2)'(2);

  // Left taps x[k-1]; replicate x[0] at line start
  logic [DAT_SZ-1:0] prev_cb_q, prev_cb_d, prev_cr_q, prev_cr_d;
  logic [DAT_SZ-1:0] nxt_cb, nxt_cr;
  logic [DAT_SZ+1:0] sum_cb, sum_cr;
`endif

  // Line tracking, stage-1 capture and chroma selection
  always_comb begin
    s1_vld = (state_q != StIdle);
    // Input is the next pixel of the line held in stage 1
    cont   = (state_q == StActive) && i_href && !i_hstr;
    take   = i_href && (i_hstr || (state_q == StActive));
    // Stage-1 pixel ends its line: hend seen, href dropped, or a new line started
    last   = (state_q == StFlush) || ((state_q == StActive) && !cont);

    state_d   = take ? (i_hend ? StFlush : StActive) : StIdle;
    s1_y_d    = s1_y_q;
    s1_cb_d   = s1_cb_q;
    s1_cr_d   = s1_cr_q;
    s1_par_d  = s1_par_q;
    s1_hstr_d = s1_hstr_q;
    s1_swap_d = s1_swap_q;
    if (take) begin
      s1_y_d    = i_data_y;
      s1_cb_d   = i_data_cb;
      s1_cr_d   = i_data_cr;
      s1_hstr_d = i_hstr;
      s1_par_d  = i_hstr ? 1'b0 : !s1_par_q;
      s1_swap_d = i_hstr ? i_c_swap : s1_swap_q;
    end

`ifdef YUV422_FILT_EN
    prev_cb_d = prev_cb_q;
    prev_cr_d = prev_cr_q;
    if (take) begin
      prev_cb_d = i_hstr ? i_data_cb : s1_cb_q;
      prev_cr_d = i_hstr ? i_data_cr : s1_cr_q;
    end
    // Right tap replicates the current pixel when it is the last of its line
    nxt_cb = cont ? i_data_cb : s1_cb_q;
    nxt_cr = cont ? i_data_cr : s1_cr_q;
    sum_cb = {2'b00, prev_cb_q} + {1'b0, s1_cb_q, 1'b0} + {2'b00, nxt_cb} + Rnd;
    sum_cr = {2'b00, prev_cr_q} + {1'b0, s1_cr_q, 1'b0} + {2'b00, nxt_cr} + Rnd;
    f_cb   = sum_cb[DAT_SZ+1:2];
    f_cr   = sum_cr[DAT_SZ+1:2];
`else
    f_cb = s1_cb_q;
    f_cr = s1_cr_q;
`endif

    first_f  = s1_swap_q ? f_cr : f_cb;
    second_f = s1_swap_q ? f_cb : f_cr;
  end

  // Output stage: emit the stage-1 pixel; odd slots replay the held second chroma
  always_comb begin
    href_d = s1_vld;
    hstr_d = s1_vld && s1_hstr_q;
    hend_d = s1_vld && last;
    sel_d  = s1_vld && (s1_par_q ^ s1_swap_q);
    y_d    = s1_vld ? s1_y_q : '0;
    c_d    = '0;
    hold_d = hold_q;
    if (s1_vld) begin
      c_d = s1_par_q ? hold_q : first_f;
      if (!s1_par_q) hold_d = second_f;
    end
  end

  // State, pipeline and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      s1_y_q    <= '0;
      s1_cb_q   <= '0;
      s1_cr_q   <= '0;
      s1_par_q  <= 1'b0;
      s1_hstr_q <= 1'b0;
      s1_swap_q <= 1'b0;
      hold_q    <= '0;
      href_q    <= 1'b0;
      hstr_q    <= 1'b0;
      hend_q    <= 1'b0;
      sel_q     <= 1'b0;
      y_q       <= '0;
      c_q       <= '0;
    end else begin
      state_q   <= state_d;
      s1_y_q    <= s1_y_d;
      s1_cb_q   <= s1_cb_d;
      s1_cr_q   <= s1_cr_d;
      s1_par_q  <= s1_par_d;
      s1_hstr_q <= s1_hstr_d;
      s1_swap_q <= s1_swap_d;
      hold_q    <= hold_d;
      href_q    <= href_d;
      hstr_q    <= hstr_d;
      hend_q    <= hend_d;
      sel_q     <= sel_d;
      y_q       <= y_d;
      c_q       <= c_d;
    end
  end

`ifdef YUV422_FILT_EN
  // Left filter taps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cb_q <= '0;
      prev_cr_q <= '0;
    end else begin
      prev_cb_q <= prev_cb_d;
      prev_cr_q <= prev_cr_d;
    end
  end
`endif

  assign o_href   = href_q;
  assign o_hstr   = hstr_q;
  assign o_hend   = hend_q;
  assign o_c_sel  = sel_q;
  assign o_data_y = y_q;
  assign o_data_c = c_q;

endmodule

// File: tb/tb_ip_yuv444to422.sv
// Directed bench for ip_yuv444to422. Each table row drives one input cycle and lists the
// output expected after the following clock edge (that of the pixel driven one row earlier,
// i.e. 2 clk latency). Chroma expectations exist for both the filtered and plain builds.
module tb_ip_yuv444to422;

  localparam int W = 10;

`ifdef YUV422_FILT_EN
  localparam bit Filt = 1'b1;
`else
  localparam bit Filt = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_href = 1'b0, i_hstr = 1'b0, i_hend = 1'b0, i_c_swap = 1'b0;
  logic [W-1:0] i_data_y = '0, i_data_cb = '0, i_data_cr = '0;
  logic         o_href, o_hstr, o_hend, o_c_sel;
  logic [W-1:0] o_data_y, o_data_c;

  int checks = 0;
  int errors = 0;

  ip_yuv444to422 #(.DAT_SZ(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_href   (i_href),
    .i_hstr   (i_hstr),
    .i_hend   (i_hend),
    .i_data_y (i_data_y),
    .i_data_cb(i_data_cb),
    .i_data_cr(i_data_cr),
    .i_c_swap (i_c_swap),
    .o_href   (o_href),
    .o_hstr   (o_hstr),
    .o_hend   (o_hend),
    .o_c_sel  (o_c_sel),
    .o_data_y (o_data_y),
    .o_data_c (o_data_c)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         href, hstr, hend, swap;
    logic [W-1:0] y, cb, cr;
    logic         e_href, e_hstr, e_hend, e_sel;
    logic [W-1:0] e_y, e_cf, e_cd;
  } vec_t;

  localparam int NV = 33;
  vec_t tbl[NV];

  function automatic vec_t mk(bit h, bit s, bit e, bit sw, int y, int cb, int cr,
                              bit eh, bit es, bit ee, bit esel, int ey, int ecf, int ecd);
    vec_t v;
    v.href = h;  v.hstr = s;  v.hend = e;  v.swap = sw;
    v.y = W'(y); v.cb = W'(cb); v.cr = W'(cr);
    v.e_href = eh; v.e_hstr = es; v.e_hend = ee; v.e_sel = esel;
    v.e_y = W'(ey); v.e_cf = W'(ecf); v.e_cd = W'(ecd);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    i_href = v.href; i_hstr = v.hstr; i_hend = v.hend; i_c_swap = v.swap;
    i_data_y = v.y; i_data_cb = v.cb; i_data_cr = v.cr;
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0);
    // 4-pixel line, swap=0
    tbl[0]  = mk(1,1,0,0, 10,100,40,  0,0,0,0, 0,0,0);
    tbl[1]  = mk(1,0,0,0, 20,200,40,  1,1,0,0, 10,125,100);
    tbl[2]  = mk(1,0,0,0, 30,300,80,  1,0,0,1, 20,40,40);
    tbl[3]  = mk(1,0,1,0, 40,400,80,  1,0,0,0, 30,300,300);
    tbl[4]  = mk(0,0,0,0, 0,0,0,      1,0,1,1, 40,70,80);
    tbl[5]  = idle;
    // 3-pixel line, full-scale chroma step
    tbl[6]  = mk(1,1,0,0, 1,0,4,      0,0,0,0, 0,0,0);
    tbl[7]  = mk(1,0,0,0, 2,1023,8,   1,1,0,0, 1,256,0);
    tbl[8]  = mk(1,0,1,0, 3,0,12,     1,0,0,1, 2,5,4);
    tbl[9]  = mk(0,0,0,0, 0,0,0,      1,0,1,0, 3,256,0);
    tbl[10] = idle;
    // One-pixel line
    tbl[11] = mk(1,1,1,0, 77,512,7,   0,0,0,0, 0,0,0);
    tbl[12] = mk(0,0,0,0, 0,0,0,      1,1,1,0, 77,512,512);
    tbl[13] = idle;
    // Back-to-back 2-pixel lines, second with swap=1 (swap low off-hstr must be ignored)
    tbl[14] = mk(1,1,0,0, 5,10,30,    0,0,0,0, 0,0,0);
    tbl[15] = mk(1,0,1,0, 6,20,50,    1,1,0,0, 5,13,10);
    tbl[16] = mk(1,1,0,1, 7,60,90,    1,0,1,1, 6,35,30);
    tbl[17] = mk(1,0,1,0, 8,80,110,   1,1,0,1, 7,95,90);
    tbl[18] = mk(0,0,0,0, 0,0,0,      1,0,1,0, 8,65,60);
    tbl[19] = idle;
    // 6-pixel line ending by href drop without hend
    tbl[20] = mk(1,1,0,0, 11,4,50,    0,0,0,0, 0,0,0);
    tbl[21] = mk(1,0,0,0, 12,8,50,    1,1,0,0, 11,5,4);
    tbl[22] = mk(1,0,0,0, 13,12,50,   1,0,0,1, 12,50,50);
    tbl[23] = mk(1,0,0,0, 14,16,50,   1,0,0,0, 13,12,12);
    tbl[24] = mk(1,0,0,0, 15,20,50,   1,0,0,1, 14,50,50);
    tbl[25] = mk(1,0,0,0, 16,24,50,   1,0,0,0, 15,20,20);
    tbl[26] = mk(0,0,0,0, 0,0,0,      1,0,1,1, 16,50,50);
    tbl[27] = idle;
    // Line truncated by hstr after 2 pixels, new one-pixel line follows directly
    tbl[28] = mk(1,1,0,0, 21,40,0,    0,0,0,0, 0,0,0);
    tbl[29] = mk(1,0,0,0, 22,80,4,    1,1,0,0, 21,50,40);
    tbl[30] = mk(1,1,1,0, 31,200,9,   1,0,1,1, 22,1,0);
    tbl[31] = mk(0,0,0,0, 0,0,0,      1,1,1,0, 31,200,200);
    tbl[32] = idle;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_href", o_href, 0);
    chk("reset_hend", o_hend, 0);
    chk("reset_c", o_data_c, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_href", i), o_href, tbl[i].e_href);
      chk($sformatf("v%0d_hstr", i), o_hstr, tbl[i].e_hstr);
      chk($sformatf("v%0d_hend", i), o_hend, tbl[i].e_hend);
      if (tbl[i].e_href) begin
        chk($sformatf("v%0d_csel", i), o_c_sel, tbl[i].e_sel);
        chk($sformatf("v%0d_y", i), o_data_y, tbl[i].e_y);
        chk($sformatf("v%0d_c", i), o_data_c, Filt ? tbl[i].e_cf : tbl[i].e_cd);
      end
    end

    // Asynchronous reset mid-line: outputs clear without waiting for a clock edge
    drive(mk(1,1,0,0, 41,300,60, 0,0,0,0, 0,0,0));
    @(posedge clk);
    #1;
    drive(mk(1,0,0,0, 42,310,70, 0,0,0,0, 0,0,0));
    @(posedge clk);
    #1;
    chk("mid_href_before_rst", o_href, 1);
    chk("mid_y_before_rst", o_data_y, 41);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_href", o_href, 0);
    chk("rst_hstr", o_hstr, 0);
    chk("rst_hend", o_hend, 0);
    chk("rst_csel", o_c_sel, 0);
    chk("rst_y", o_data_y, 0);
    chk("rst_c", o_data_c, 0);
    drive(mk(0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // No partial flush of the interrupted line after reset
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_href%0d", i), o_href, 0);
      chk($sformatf("post_rst_hend%0d", i), o_hend, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ip_yuv444to422.md
Name: ip_yuv444to422

Overview:
Downstream neighbour of ip_rgb2yuv. Converts the per-pixel YCbCr 4:4:4 stream from ip_rgb2yuv into a line-synchronous 4:2:2 stream with one chroma sample per pixel slot. Chroma is horizontally low-pass filtered with a [1 2 1]/4 kernel, co-sited on even pixels, before decimation. It sits between ip_rgb2yuv and the YUV output/packing stage, and is driven by the sensor href/hstr/hend timing.

Parameters:
DAT_SZ, 10, bit width of Y/Cb/Cr samples in and out

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
i_href  input  1  pixel valid; contiguous from i_hstr to i_hend within a line
i_hstr  input  1  first pixel of line; only valid with i_href=1
i_hend  input  1  last pixel of line; only valid with i_href=1; may coincide with i_hstr
i_data_y  input  DAT_SZ  luma
i_data_cb  input  DAT_SZ  Cb
i_data_cr  input  DAT_SZ  Cr
i_c_swap  input  1  0: even slot carries Cb and odd slot carries Cr; 1: reversed; sampled at i_hstr only
o_href  output  1  output pixel valid
o_hstr  output  1  first output pixel of line
o_hend  output  1  last output pixel of line
o_c_sel  output  1  chroma id of o_data_c: 0=Cb, 1=Cr
o_data_y  output  DAT_SZ  luma, delayed
o_data_c  output  DAT_SZ  interleaved filtered chroma

Behaviour:
- Reset: all outputs 0; FSM to IDLE; pixel parity, tap registers and Cr hold register cleared.
- Latency: every output equals its input pixel delayed by exactly 2 clk, including o_href/o_hstr/o_hend. Y is passed unchanged.
- Pixel index k counts from 0 at i_hstr. For each even k, let F(x,k) = (x[k-1] + 2*x[k] + x[k+1] + 2) >> 2.
  - Compute in DAT_SZ+2 bits.
  - The result never exceeds 2^DAT_SZ-1, so no clip is required.
- Edge replication: x[-1]=x[0]. If pixel k is the last pixel of the line, x[k+1]=x[k].
- Even output slot k: o_data_c = F(first chroma, k).
- Odd output slot k+1: o_data_c = F(second chroma, k), where k is the preceding even pixel.
  - The odd slot's own input chroma is used only as a tap.
  - The second-chroma result is computed in the even slot and held one cycle.
- o_c_sel = parity(k) XOR latched i_c_swap.
- FSM states:
  - IDLE → ACTIVE on i_href&i_hstr.
  - ACTIVE → FLUSH on i_hend, or on i_href falling without i_hend (implicit end).
  - FLUSH lasts 1 cycle and emits the final pixel using replication, then returns to IDLE.
  - If i_hstr arrives during FLUSH, go straight to ACTIVE for the new line (zero-gap lines supported).
- Odd line length: the last pixel is even. It is emitted with the first chroma only; there is no extra padding pixel. o_hend marks it.
- One-pixel line (i_hstr & i_hend together): single output with o_hstr=o_hend=1 and o_data_c = first chroma of that pixel.
- Implicit end (href drops without hend): the last received pixel is output with o_hend=1, so the output line is always terminated.
- i_hstr while ACTIVE (no preceding hend): the current line is truncated.
  - Its last pixel is emitted with o_hend=1.
  - The new line restarts at k=0 in the following slot, with no loss or duplication of pixels.
- Asynchronous reset mid-line: output drops immediately; no partial flush.

Optional Feature:
YUV422_FILT_EN — when defined, chroma uses the [1 2 1]/4 filter above. When undefined, plain decimation: even slot outputs x_first[k], odd slot outputs x_second[k] from the preceding even pixel. Latency stays 2 clk and timing outputs are unchanged. Tap adders are removed; the one-cycle hold register remains.

Test Plan:
- 4-pixel line, Y=10,20,30,40, Cb=100,200,300,400, Cr=40,40,80,80, swap=0, FILT_EN → o_href 2 clk later; C=125,40,300,70; c_sel=0,1,0,1; Y=10,20,30,40; hstr on slot0, hend on slot3.
- 3-pixel line, Cb=0,1023,0, FILT_EN → even slot0 = (0+0+1023+2)>>2 = 256; last even slot2 = (1023+0+0+2)>>2 = 256 with hend; 3 output pixels.
- One-pixel line, hstr=hend, Cb=512, Cr=7 → one output, C=512, c_sel=0, hstr=hend=1.
- Back-to-back 2-pixel lines with zero gap and i_c_swap=1 on the second → continuous o_href for 4 cycles; second line c_sel=1,0; no dropped or duplicated pixel.
- i_href falls after pixel 5 without hend → pixel 5 output with o_hend=1, then IDLE; also assert rst_n low mid-line → all outputs 0 in the same cycle.
- Build without YUV422_FILT_EN, first vector → C=100,40,300,80.
